// File: rtl/tape_scope.sv
// tape_scope: rolling strip display of the 1-bit cassette signal.
// The tape bit is sampled every SAMPLE_DIV clocks into a 256x1 ring buffer.
// The last 256 samples are drawn as a two-level trace in a band of the
// visible picture. The result is an 8-bit red intensity, to be ORed into R.
//
// Ports:
//   clk_video  video clock, all logic on the rising edge
//   reset      synchronous, active-high
//   ce_pix     pixel enable (pulses at least 3 clocks apart)
//   hblank     horizontal blank
//   vblank     vertical blank
//   tape_in    tape bit, asynchronous (synchronized internally)
//   en         display and capture enable
//   freeze     stops capture and keeps the displayed trace
//   color      red intensity, 8'h00 outside the strip
module tape_scope #(
   parameter int unsigned SAMPLE_DIV = 1024,
   parameter int unsigned X_START    = 64,
   parameter int unsigned Y_TOP      = 176,
   parameter int unsigned BAND_H     = 16
) (
   input  logic       clk_video,
   input  logic       reset,
   input  logic       ce_pix,
   input  logic       hblank,
   input  logic       vblank,
   input  logic       tape_in,
   input  logic       en,
   input  logic       freeze,
   output logic [7:0] color
);

   localparam int unsigned DW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
   localparam int unsigned HW = 12;
   localparam int unsigned VW = 11;

   localparam logic [DW-1:0] DIV_MAX = DW'(SAMPLE_DIV - 1);
   localparam logic [HW-1:0] X_LO    = HW'(X_START);
   localparam logic [HW-1:0] X_HI    = HW'(X_START + 255);
   localparam logic [VW-1:0] Y_LO    = VW'(Y_TOP);
   localparam logic [VW-1:0] Y_HI    = VW'(Y_TOP + BAND_H - 1);

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      RUN   = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t          state, state_nx;
   logic [1:0]      tape_sync;
   logic            tape_s;
   logic [7:0]      clr_cnt;
   logic [DW-1:0]   div;
   logic [7:0]      wr_ptr;
   logic [7:0]      start_ptr;
   logic            vblank_d, hblank_d;
   logic [HW-1:0]   hpos;
   logic [VW-1:0]   vline;

   logic            capture_on, sample_now;
   logic            we, wd;
   logic [7:0]      wa;
   logic            mem [0:255];
   logic [7:0]      col, rd_addr;
   logic            rd_data;
   logic            in_strip;

   logic            ce_d;
   logic            p_in, p_top, p_bot, p_first;
   logic            prev_s, prev_use, hit;
   logic [7:0]      pix;

   // tape synchronizer
   always_ff @(posedge clk_video) begin
      if (reset) tape_sync <= '0;
      else       tape_sync <= {tape_sync[0], tape_in};
   end
   assign tape_s = tape_sync[1];

   // state machine
   always_ff @(posedge clk_video) begin
      if (reset) state <= CLEAR;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         CLEAR:   if (clr_cnt == 8'hFF)   state_nx = RUN;
         RUN:     if (freeze || !en)      state_nx = HOLD;
         HOLD:    if (!freeze && en)      state_nx = RUN;
         default:                         state_nx = CLEAR;
      endcase
   end

   always_ff @(posedge clk_video) begin
      if (reset)               clr_cnt <= '0;
      else if (state == CLEAR) clr_cnt <= clr_cnt + 8'd1;
   end

   // The en/freeze inputs gate capture directly, so capture stops on the
   // same edge that they change, before the state register catches up.
   assign capture_on = (state == RUN) && en && !freeze;
   assign sample_now = capture_on && (div == DIV_MAX);

   always_ff @(posedge clk_video) begin
      if (reset) begin
         div    <= '0;
         wr_ptr <= '0;
      end else if (capture_on) begin
         if (div == DIV_MAX) begin
            div    <= '0;
            wr_ptr <= wr_ptr + 8'd1;
         end else begin
            div <= div + 1'b1;
         end
      end
   end

   // single write port shared between clear and sampler
   always_comb begin
      we = (state == CLEAR) || sample_now;
      wa = (state == CLEAR) ? clr_cnt : wr_ptr;
      wd = (state == CLEAR) ? 1'b0 : tape_s;
   end

   // read-before-write: a same-address read returns the old entry
   always_ff @(posedge clk_video) begin
      if (we) mem[wa] <= wd;
      rd_data <= mem[rd_addr];
   end

   // frame snapshot and raster position
   always_ff @(posedge clk_video) begin
      if (reset) begin
         vblank_d  <= 1'b0;
         hblank_d  <= 1'b0;
         start_ptr <= '0;
         hpos      <= '0;
         vline     <= '0;
      end else begin
         vblank_d <= vblank;
         hblank_d <= hblank;
         if (vblank && !vblank_d) start_ptr <= wr_ptr;
         if (hblank)      hpos <= '0;
         else if (ce_pix) hpos <= hpos + 1'b1;
         if (vblank)                    vline <= '0;
         else if (hblank && !hblank_d)  vline <= vline + 1'b1;
      end
   end

   assign col      = 8'(hpos - X_LO);
   assign rd_addr  = start_ptr + col;
   assign in_strip = (vline >= Y_LO) && (vline <= Y_HI) &&
                     (hpos >= X_LO) && (hpos <= X_HI) && !hblank && !vblank;

   // stage 1: address issued on ce_pix, row/column flags kept alongside
   always_ff @(posedge clk_video) begin
      if (reset) begin
         ce_d    <= 1'b0;
         p_in    <= 1'b0;
         p_top   <= 1'b0;
         p_bot   <= 1'b0;
         p_first <= 1'b0;
      end else begin
         ce_d <= ce_pix;
         if (ce_pix) begin
            p_in    <= in_strip;
            p_top   <= (vline == Y_LO);
            p_bot   <= (vline == Y_HI);
            p_first <= (col == 8'd0);
         end
      end
   end

   // stage 2: pixel rule; column 0 compares against itself (no edge)
   always_comb begin
      prev_use = p_first ? rd_data : prev_s;
      hit      = (rd_data && p_top) || (!rd_data && p_bot) || (rd_data != prev_use);
      pix      = hit ? 8'hFF : 8'h30;
   end

   always_ff @(posedge clk_video) begin
      if (reset)     prev_s <= 1'b0;
      else if (ce_d) prev_s <= rd_data;
   end

   always_ff @(posedge clk_video) begin
      if (reset || (state == CLEAR) || !en || hblank || vblank)
         color <= 8'h00;
      else if (ce_d)
         color <= p_in ? pix : 8'h00;
   end

endmodule

// File: tb/tb_tape_scope.sv
// tb_tape_scope: directed bench for tape_scope with a small strip geometry
// (X_START=4, Y_TOP=2, BAND_H=4, SAMPLE_DIV=4). Drives a simple raster with
// ce_pix every third clock and captures each pixel 2 clocks after its ce_pix.
module tb_tape_scope;

   localparam int XS    = 4;
   localparam int YT    = 2;
   localparam int BH    = 4;
   localparam int LINES = 7;
   localparam int PIX   = 262;

   logic       clk_video = 1'b0;
   logic       reset     = 1'b1;
   logic       ce_pix    = 1'b0;
   logic       hblank    = 1'b0;
   logic       vblank    = 1'b0;
   logic       tape_in   = 1'b0;
   logic       en        = 1'b1;
   logic       freeze    = 1'b0;
   logic [7:0] color;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   logic [7:0] cap [0:LINES][0:PIX-1];
   bit         bm  [0:255];

   tape_scope #(
      .SAMPLE_DIV (4),
      .X_START    (XS),
      .Y_TOP      (YT),
      .BAND_H     (BH)
   ) dut (
      .clk_video (clk_video),
      .reset     (reset),
      .ce_pix    (ce_pix),
      .hblank    (hblank),
      .vblank    (vblank),
      .tape_in   (tape_in),
      .en        (en),
      .freeze    (freeze),
      .color     (color)
   );

   always #5 clk_video = ~clk_video;

   task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk_video);
   endtask

   task automatic wait_ptr(input string tag, input int unsigned val, input int budget,
                           output int cycles);
      cycles = 0;
      while (dut.wr_ptr != 8'(val) && cycles < budget) begin
         @(negedge clk_video);
         cycles++;
      end
      if (dut.wr_ptr != 8'(val)) chk(tag, dut.wr_ptr, val);
   endtask

   function automatic logic [7:0] exp_pix(int l, int h, int sp, int dl, int dh);
      int c;
      bit s, p;
      if (dl >= 0 && (l > dl || (l == dl && h >= dh))) return 8'h00;
      if (l < YT || l > YT + BH - 1 || h < XS || h > XS + 255) return 8'h00;
      c = h - XS;
      s = bm[(sp + c) % 256];
      p = (c == 0) ? s : bm[(sp + c - 1) % 256];
      if ((s && l == YT) || (!s && l == YT + BH - 1) || (s != p)) return 8'hFF;
      return 8'h30;
   endfunction

   task automatic run_frame(input int dl, input int dh, input bit tog);
      hblank = 1'b0;
      vblank = 1'b1;
      cyc(4);
      vblank = 1'b0;
      cyc(1);
      for (int l = 1; l <= LINES; l++) begin
         hblank = 1'b1;
         cyc(4);
         hblank = 1'b0;
         for (int h = 0; h < PIX; h++) begin
            if (l == dl && h == dh) en = 1'b0;
            ce_pix = 1'b1;
            if (tog) tape_in = ~tape_in;
            cyc(1);
            ce_pix = 1'b0;
            cyc(2);
            cap[l][h] = color;
         end
      end
      hblank = 1'b1;
      cyc(2);
   endtask

   task automatic cmp_img(input string tag, input int sp, input int dl, input int dh);
      int bad = 0;
      for (int l = 1; l <= LINES; l++)
         for (int h = 0; h < PIX; h++)
            if (cap[l][h] !== exp_pix(l, h, sp, dl, dh)) bad++;
      chk(tag, bad, 0);
   endtask

   task automatic count_ones(input int lo, input int hi, output int n);
      n = 0;
      for (int i = lo; i <= hi; i++) if (dut.mem[i] === 1'b1) n++;
   endtask

   initial begin
      int bad, t, n;

      for (int i = 0; i < 256; i++) bm[i] = (i >= 128);

      // reset values
      reset = 1'b1;
      cyc(3);
      chk("rst_color", color, 8'h00);
      chk("rst_wr_ptr", dut.wr_ptr, 0);
      chk("rst_start_ptr", dut.start_ptr, 0);
      chk("rst_state", int'(dut.state), 0);
      chk("rst_hpos", dut.hpos, 0);

      // clear sweep: 256 cycles in CLEAR with color 0, then RUN
      reset = 1'b0;
      bad = 0;
      repeat (255) begin
         cyc(1);
         if (color != 8'h00 || int'(dut.state) != 0) bad++;
      end
      chk("clear_phase", bad, 0);
      cyc(1);
      chk("run_after_clear", int'(dut.state), 1);

      // sample cadence
      wait_ptr("tmo_p1", 1, 50, t);
      chk("first_sample_cycles", t, 4);
      wait_ptr("tmo_p2", 2, 50, t);
      chk("sample_period", t, 4);

      // fill 128 zeros then 128 ones
      wait_ptr("tmo_p128", 128, 1000, t);
      tape_in = 1'b1;
      wait_ptr("tmo_wrap", 0, 1000, t);
      chk("wrap_cycles", t, 512);
      freeze = 1'b1;
      cyc(1);
      chk("hold_state", int'(dut.state), 2);
      count_ones(0, 127, n);
      chk("ones_low_half", n, 0);
      count_ones(128, 255, n);
      chk("ones_high_half", n, 128);

      // frozen frames with tape toggling
      run_frame(-1, 0, 1'b1);
      chk("start_ptr_snap", dut.start_ptr, 0);
      chk("bot_c0", cap[5][4], 8'hFF);
      chk("bot_c127", cap[5][131], 8'hFF);
      chk("top_c128", cap[2][132], 8'hFF);
      chk("top_c255", cap[2][259], 8'hFF);
      chk("edge_row3", cap[3][132], 8'hFF);
      chk("edge_row4", cap[4][132], 8'hFF);
      chk("c0_no_edge", cap[3][4], 8'h30);
      chk("bg_top_c46", cap[2][50], 8'h30);
      chk("bg_bot_c196", cap[5][200], 8'h30);
      chk("left_outside", cap[3][3], 8'h00);
      chk("right_outside", cap[3][260], 8'h00);
      chk("line_above", cap[1][100], 8'h00);
      chk("line_below", cap[6][100], 8'h00);
      cmp_img("frz_frame1", 0, -1, 0);
      chk("frz_ptr1", dut.wr_ptr, 0);
      run_frame(-1, 0, 1'b1);
      cmp_img("frz_frame2", 0, -1, 0);
      chk("frz_ptr2", dut.wr_ptr, 0);
      run_frame(-1, 0, 1'b1);
      cmp_img("frz_frame3", 0, -1, 0);
      chk("frz_ptr3", dut.wr_ptr, 0);

      // en low: nothing drawn
      en = 1'b0;
      run_frame(-1, 0, 1'b1);
      bad = 0;
      for (int l = 1; l <= LINES; l++)
         for (int h = 0; h < PIX; h++)
            if (cap[l][h] != 8'h00) bad++;
      chk("en0_blank", bad, 0);
      chk("en0_ptr", dut.wr_ptr, 0);

      // en dropped mid-line, then restored for the next frame
      en = 1'b1;
      run_frame(3, 100, 1'b0);
      cmp_img("en_drop", 0, 3, 100);
      en = 1'b1;
      run_frame(-1, 0, 1'b0);
      cmp_img("en_back", 0, -1, 0);

      // release freeze: capture resumes from the held pointer and divider
      freeze  = 1'b0;
      tape_in = 1'b1;
      wait_ptr("tmo_resume", 1, 50, t);
      chk("resume_cycles", t, 5);

      // reset mid-run at wr_ptr 0x5A
      wait_ptr("tmo_5a", 8'h5A, 1000, t);
      reset = 1'b1;
      cyc(1);
      chk("rr_state", int'(dut.state), 0);
      chk("rr_wr_ptr", dut.wr_ptr, 0);
      chk("rr_color", color, 8'h00);
      chk("rr_clr_cnt", dut.clr_cnt, 0);
      reset = 1'b0;
      cyc(256);
      chk("rr_run", int'(dut.state), 1);
      count_ones(0, 255, n);
      chk("rr_all_zero", n, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
